// File: rtl/key_ctl_pkg.sv
// rtl/key_ctl_pkg.sv - classifier state type and width/polarity helpers for multi_key_ctl
package key_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } cls_state_e;

  // Raw pin level of an untouched key: high for active-low wiring
  function automatic logic released_raw(input int active_low);
    return (active_low != 0);
  endfunction

  function automatic int cnt_w(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/key_ch.sv
// rtl/key_ch.sv - one key channel: sync, debounce, short/long classifier, mode counter
// Optional KEY_CTL_AUTOREPEAT_EN: long press increments and auto-repeats instead of clearing.
module key_ch
  import key_ctl_pkg::*;
#(
  parameter int CNT_WIDTH      = 2,
  parameter int CNT_MAX        = 2,
  parameter int DEB_CYCLES     = 20'h7_ffff,
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key,
  output logic                 key_level,
  output logic                 short_pulse,
  output logic                 long_pulse,
  output logic [CNT_WIDTH-1:0] ctrl
);

  localparam int DW = cnt_w(DEB_CYCLES);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam logic                 RAW_REL   = released_raw(KEY_ACTIVE_LOW);
  localparam logic [DW-1:0]        DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(CNT_MAX);

  logic          sync0, sync1, lvl, stable;
  logic [DW-1:0] deb_cnt;
  logic          toggle, rise_evt, fall_evt;

  cls_state_e    state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          short_nxt, long_nxt;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign lvl       = sync1 ^ RAW_REL;
  assign toggle    = (lvl != stable) && (deb_cnt == DEB_LAST);
  assign rise_evt  = toggle && !stable;
  assign fall_evt  = toggle && stable;
  assign key_level = stable;
  assign cnt_inc   = (ctrl == CNT_LAST) ? '0 : ctrl + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0   <= RAW_REL;
      sync1   <= RAW_REL;
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync0 <= key;
      sync1 <= sync0;
      if (lvl == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        stable  <= ~stable;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

`ifdef KEY_CTL_AUTOREPEAT_EN
  localparam int RW = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt, rep_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt <= '0;
    else        rep_cnt <= rep_nxt;
  end
`endif

  // Classifier consumes the debounce toggle directly so pulses line up with key_level edges
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
`ifdef KEY_CTL_AUTOREPEAT_EN
    rep_nxt   = rep_cnt;
`endif
    case (state)
      IDLE: begin
        if (rise_evt) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
        end
      end
      PRESSED: begin
        if (fall_evt) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
`ifdef KEY_CTL_AUTOREPEAT_EN
          rep_nxt   = '0;
`endif
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall_evt) begin
          state_nxt = IDLE;
`ifdef KEY_CTL_AUTOREPEAT_EN
        end else if (rep_cnt == REP_LAST) begin
          long_nxt = 1'b1;
          rep_nxt  = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      short_pulse <= short_nxt;
      long_pulse  <= long_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
`ifdef KEY_CTL_AUTOREPEAT_EN
    end else if (short_pulse || long_pulse) begin
      ctrl <= cnt_inc;
`else
    end else if (short_pulse) begin
      ctrl <= cnt_inc;
    end else if (long_pulse) begin
      ctrl <= '0;
`endif
    end
  end

endmodule

// File: rtl/multi_key_ctl.sv
// rtl/multi_key_ctl.sv - N-channel user-key controller with packed mode counters
// Optional KEY_CTL_AUTOREPEAT_EN: long press increments and auto-repeats instead of clearing.
module multi_key_ctl
  import key_ctl_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int CNT_WIDTH      = 2,
  parameter int CNT_MAX        = 2,
  parameter int DEB_CYCLES     = 20'h7_ffff,
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_KEYS-1:0]             key,
  output logic [N_KEYS-1:0]             key_level,
  output logic [N_KEYS-1:0]             short_pulse,
  output logic [N_KEYS-1:0]             long_pulse,
  output logic [N_KEYS*CNT_WIDTH-1:0]   ctrl
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_ch #(
      .CNT_WIDTH      (CNT_WIDTH),
      .CNT_MAX        (CNT_MAX),
      .DEB_CYCLES     (DEB_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key         (key[i]),
      .key_level   (key_level[i]),
      .short_pulse (short_pulse[i]),
      .long_pulse  (long_pulse[i]),
      .ctrl        (ctrl[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: doc/multi_key_ctl.md
# multi_key_ctl

Parametrised multi-channel push-button controller for the board's user keys. Each channel synchronises and debounces one raw key, classifies presses as short or long, and maintains a wrap-around mode counter that downstream video/ISP blocks use as a selector. It replaces per-key single-counter instances with one block offering per-key events, long-press behaviour and configurable polarity.

## Interface
Parameters:
- N_KEYS, 4, number of independent key channels (1..16)
- CNT_WIDTH, 2, width of each channel's mode counter
- CNT_MAX, 2, last counter value before wrap to 0; must be < 2**CNT_WIDTH
- DEB_CYCLES, 20'h7_ffff, consecutive stable cycles required to accept a level change (>= 2)
- LONG_CYCLES, 50_000_000, cycles of held press that qualify as a long press (> DEB_CYCLES)
- REPEAT_CYCLES, 10_000_000, auto-repeat period (used only with KEY_CTL_AUTOREPEAT_EN)
- KEY_ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: reads 1 when pressed

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key  input  N_KEYS  raw key pins, asynchronous to clk
- key_level  output  N_KEYS  debounced level, 1 = pressed (polarity normalised)
- short_pulse  output  N_KEYS  one-cycle pulse per short press, on release
- long_pulse  output  N_KEYS  one-cycle pulse when held press reaches LONG_CYCLES
- ctrl  output  N_KEYS*CNT_WIDTH  packed mode counters; channel i at [i*CNT_WIDTH +: CNT_WIDTH]

## Operation
- Per channel: 2-flop synchroniser -> polarity normalise -> debounce -> press classifier -> mode counter. Channels fully independent; simultaneous events on different channels all take effect in the same cycle.
- Debounce: deb_cnt clears whenever synchronised level equals stable level; otherwise increments. When deb_cnt reaches DEB_CYCLES-1 with mismatch still present, stable level toggles and deb_cnt clears. Any single-cycle agreement restarts the count (glitches shorter than DEB_CYCLES are rejected).
- Classifier states: IDLE, PRESSED, LONG_HELD.
  - IDLE -> PRESSED on stable 0->1; hold_cnt cleared.
  - PRESSED: hold_cnt increments each cycle; when it reaches LONG_CYCLES-1 -> LONG_HELD, long_pulse asserted that cycle. Stable 1->0 while PRESSED -> IDLE, short_pulse asserted that cycle.
  - LONG_HELD: no further events (except auto-repeat, see Configuration); stable 1->0 -> IDLE, no short_pulse.
- short_pulse and long_pulse never assert in the same cycle for one channel.
- Mode counter: on short_pulse, cnt = (cnt == CNT_MAX) ? 0 : cnt + 1; on long_pulse (macro undefined), cnt = 0. Counter width exactly CNT_WIDTH; values > CNT_MAX never produced.

## Timing
- Reset values: key_level = 0, short_pulse = 0, long_pulse = 0, ctrl = 0; synchroniser flops and stable level reset to the released state; classifier in IDLE; all counters 0.
- Latency clean raw edge -> key_level change: 2 (sync) + DEB_CYCLES cycles.
- key_level falling edge -> short_pulse same cycle; ctrl updates the following cycle.
- long_pulse asserts LONG_CYCLES cycles after key_level rises (key_level rise = cycle 0, hold_cnt reaching LONG_CYCLES-1 on cycle LONG_CYCLES-1, pulse registered on next edge); ctrl updates one cycle after the pulse.
- Reset asserted mid-press: all state cleared immediately; a key still held after rst_n deasserts is treated as a new press once debounced.
- hold_cnt and deb_cnt widths: $clog2 of their limits + 1; no overflow possible (hold_cnt stops in LONG_HELD).

## Configuration
- KEY_CTL_AUTOREPEAT_EN defined: long_pulse increments cnt (same wrap rule) instead of clearing it; in LONG_HELD a repeat counter emits an additional long_pulse + increment every REPEAT_CYCLES cycles until release; release from LONG_HELD emits nothing.
- Undefined: long_pulse clears cnt to 0 once; no repeat logic synthesised.

## Structure
- Shared package key_ctl_pkg: classifier state enum (IDLE/PRESSED/LONG_HELD), released-level constant helper, width function wrappers.
- One sub-module key_ch: single-channel sync + debounce + classifier + counter; top generates N_KEYS instances and packs ctrl.

## Test plan
(Bench uses DEB_CYCLES=8, LONG_CYCLES=64, REPEAT_CYCLES=16, CNT_MAX=2, KEY_ACTIVE_LOW=1.)
- Reset: rst_n low then high, keys at 1 -> all outputs 0, ctrl = 0 for 10+ cycles.
- Bounce: key 0 for 5 cycles, 1 for 3, then 0 held 20 cycles -> key_level rises exactly 10 cycles after final falling raw edge; no pulse on glitch.
- Short presses: three presses of 30 cycles on ch0 -> three short_pulse, ctrl[1:0] sequence 1,2,0; other channels unchanged.
- Long press: hold ch1 for 100 cycles -> one long_pulse 64 cycles after key_level rise, ctrl ch1 = 0, no short_pulse on release; with KEY_CTL_AUTOREPEAT_EN -> pulses at 64, 80, 96, ctrl ch1 wraps 1,2,0.
- Simultaneous: short press on ch2 and ch3 released same cycle -> both short_pulse same cycle, both counters +1.
- Reset mid-press: assert rst_n during a 40-cycle hold -> ctrl cleared; press re-detected after debounce, no short_pulse at reset.
